cmvn_frame_ctrl: RTL and testbench

Frame-level initiator for the `cmvn` normalisation engine. It buffers one 20-feature fbank frame from the feature extractor and issues the features to the engine one per cycle with matching `feature_idx`. It collects the returned normalised values in arrival order and streams the normalised frame to the downstream classifier input with valid/ready. It also watches for a stalled engine and flags it.

---
 rtl/cmvn_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_cmvn_frame_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmvn_frame_ctrl.sv
// Frame controller for the cmvn engine. It buffers one fbank frame, issues the features
// to the engine, collects the normalised results in arrival order and streams them out.
module cmvn_frame_ctrl #(
  parameter int NUM_FEAT = 20,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          cmvn_en,
  output logic [DW-1:0] cmvn_data,
  output logic [4:0]    cmvn_idx,
  input  logic [DW-1:0] cmvn_result,
  input  logic          cmvn_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_idx,
  output logic          out_last,
  input  logic          out_ready,
  output logic [15:0]   frame_cnt,
  output logic          timeout_err
);

  localparam int             WDW        = $clog2(TIMEOUT + 1);
  localparam logic [4:0]     LAST_IDX   = 5'(NUM_FEAT - 1);
  localparam logic [4:0]     FULL_CNT   = 5'(NUM_FEAT);
  localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [DW-1:0]  ibuf_reg [NUM_FEAT];
  logic [DW-1:0]  rbuf_reg [NUM_FEAT];
  logic [4:0]     wp_reg, ip_reg, cap_reg, rp_reg;
  logic [WDW-1:0] wdog_reg;
  logic [15:0]    frame_cnt_reg;
  logic           timeout_err_reg;

  logic load_beat, cap_we, cap_full, send_beat, wdog_expire;

  always_comb begin
    state_next  = state_reg;
    load_beat   = (state_reg == S_LOAD) && in_valid;
    cap_we      = ((state_reg == S_ISSUE) || (state_reg == S_DRAIN)) && cmvn_done
                  && (cap_reg != FULL_CNT);
    cap_full    = cap_we && (cap_reg == LAST_IDX);
    send_beat   = (state_reg == S_SEND) && out_ready;
    wdog_expire = (state_reg == S_DRAIN) && !cmvn_done && (wdog_reg == WDOG_LIMIT);

    in_ready  = (state_reg == S_LOAD);
    cmvn_en   = (state_reg == S_ISSUE);
    cmvn_idx  = cmvn_en ? ip_reg : 5'd0;
    cmvn_data = cmvn_en ? ibuf_reg[ip_reg] : '0;
    out_valid = (state_reg == S_SEND);
    out_idx   = out_valid ? rp_reg : 5'd0;
    out_data  = out_valid ? rbuf_reg[rp_reg] : '0;
    out_last  = out_valid && (rp_reg == LAST_IDX);

    case (state_reg)
      S_LOAD:  if (load_beat && (wp_reg == LAST_IDX)) state_next = S_ISSUE;
      // A zero-latency engine can complete the frame while still issuing.
      S_ISSUE: begin
        if (cap_full)                    state_next = S_SEND;
        else if (ip_reg == LAST_IDX)     state_next = S_DRAIN;
      end
      S_DRAIN: if (cap_full || wdog_expire) state_next = S_SEND;
      S_SEND:  if (send_beat && (rp_reg == LAST_IDX)) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_LOAD;
      wp_reg          <= '0;
      ip_reg          <= '0;
      cap_reg         <= '0;
      rp_reg          <= '0;
      wdog_reg        <= '0;
      frame_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
      for (int i = 0; i < NUM_FEAT; i++) begin
        ibuf_reg[i] <= '0;
        rbuf_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;

      if (load_beat) begin
        ibuf_reg[wp_reg] <= in_data;
        wp_reg           <= (wp_reg == LAST_IDX) ? 5'd0 : wp_reg + 5'd1;
      end

      if ((state_reg == S_LOAD) && (state_next == S_ISSUE)) begin
        cap_reg <= '0;
        ip_reg  <= '0;
        for (int i = 0; i < NUM_FEAT; i++) rbuf_reg[i] <= '0;
      end

      if (state_reg == S_ISSUE) ip_reg <= (ip_reg == LAST_IDX) ? 5'd0 : ip_reg + 5'd1;

      if (cap_we) begin
        rbuf_reg[cap_reg] <= cmvn_result;
        cap_reg           <= cap_reg + 5'd1;
      end

      // Watchdog measures idle cycles only while draining; any other state holds it at zero.
      if ((state_reg == S_DRAIN) && !cmvn_done) wdog_reg <= wdog_reg + 1'b1;
      else                                      wdog_reg <= '0;

      if (wdog_expire) timeout_err_reg <= 1'b1;

      if (send_beat) begin
        rp_reg <= (rp_reg == LAST_IDX) ? 5'd0 : rp_reg + 5'd1;
        if (rp_reg == LAST_IDX) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_cnt   = frame_cnt_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_cmvn_frame_ctrl.sv
// Bench for cmvn_frame_ctrl: directed frame scenarios with random data, a delay-line engine
// model and an expected-output model built from per-frame arithmetic.
module tb_cmvn_frame_ctrl;

  localparam int NF = 20;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, cmvn_en, cmvn_done, out_valid, out_last, timeout_err;
  logic [DW-1:0] cmvn_data, cmvn_result, out_data;
  logic [4:0]    cmvn_idx, out_idx;
  logic [15:0]   frame_cnt;

  cmvn_frame_ctrl #(.NUM_FEAT(NF), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmvn_en(cmvn_en), .cmvn_data(cmvn_data), .cmvn_idx(cmvn_idx),
    .cmvn_result(cmvn_result), .cmvn_done(cmvn_done),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Engine: returns data+idx after eng_lat cycles, for the first eng_limit issues only.
  int          eng_lat = 2;
  int          eng_limit = NF;
  int          iss_cnt = 0;
  logic        pv [16];
  logic [31:0] pd [16];

  always @(posedge clk) begin
    if (rst || in_ready) iss_cnt <= 0;
    else if (cmvn_en)    iss_cnt <= iss_cnt + 1;
    for (int i = 15; i > 0; i--) begin
      pv[i] <= rst ? 1'b0 : pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= !rst && cmvn_en && (iss_cnt < eng_limit);
    pd[0] <= cmvn_data + 32'(cmvn_idx);
  end

  assign cmvn_done   = (eng_lat == 0) ? (cmvn_en && (iss_cnt < eng_limit)) : pv[eng_lat-1];
  assign cmvn_result = (eng_lat == 0) ? (cmvn_data + 32'(cmvn_idx)) : pd[eng_lat-1];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] xv [NF];
  logic [15:0] exp_fc = 16'd0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cmvn_en", cmvn_en, 0);
    chk("rst_cmvn_data", cmvn_data, 0);
    chk("rst_cmvn_idx", cmvn_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  task automatic load_inputs(input bit basic);
    int k = 0;
    int guard = 0;
    for (int i = 0; i < NF; i++) xv[i] = basic ? (32'd300000000 + 32'(i)) : $urandom;
    while (k < NF && guard < 400) begin
      @(negedge clk);
      guard++;
      in_valid = basic ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data  = xv[k];
      if (in_valid && in_ready) k++;
    end
    chk("load_beats", k, NF);
  endtask

  // Runs one frame: L = engine latency, M = results the engine returns, mode = out_ready pattern.
  task automatic run_frame(input int L, input int M, input int mode, input bit basic);
    int   n = 0;
    int   beat = 0;
    int   first_v = -1;
    int   last_done = -1;
    int   err_rise = -1;
    int   exp_first;
    int   drain_ref;
    logic err_before;
    logic [31:0] expd;
    eng_lat = L;
    eng_limit = M;
    err_before = exp_err;
    load_inputs(basic);
    while (beat < NF && n < 300) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      chk("in_ready_busy", in_ready, 0);
      chk("cmvn_en", cmvn_en, (n <= NF) ? 1 : 0);
      if (n <= NF) begin
        chk("cmvn_idx", cmvn_idx, n - 1);
        chk("cmvn_data", cmvn_data, xv[n-1]);
      end
      if (cmvn_done) last_done = n;
      if (!err_before && timeout_err && err_rise < 0) err_rise = n;
      if (first_v >= 0) chk("out_valid_hold", out_valid, 1);
      if (out_valid) begin
        if (first_v < 0) first_v = n;
        expd = (beat < M) ? (xv[beat] + 32'(beat)) : 32'd0;
        chk("out_idx", out_idx, beat);
        chk("out_data", out_data, expd);
        chk("out_last", out_last, (beat == NF - 1) ? 1 : 0);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) beat++;
    end
    chk("frame_beats", beat, NF);
    if (M == NF) begin
      exp_first = NF + 1 + L;
    end else begin
      drain_ref = (M + L > NF) ? (M + L) : NF;
      exp_first = drain_ref + TO + 1;
      chk("last_done", last_done, M + L);
      if (!err_before) chk("timeout_rise", err_rise, exp_first);
    end
    chk("first_valid", first_v, exp_first);
    exp_fc = exp_fc + 16'd1;
    if (M < NF) exp_err = 1'b1;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_frame_cnt", frame_cnt, exp_fc);
    chk("post_timeout_err", timeout_err, exp_err);
    $display("frame L=%0d results=%0d mode=%0d first_valid=%0d frame_cnt=%0d timeout_err=%0b",
             L, M, mode, first_v, frame_cnt, timeout_err);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Basic frame with the documented data pattern.
    run_frame(2, NF, 0, 1'b1);
    // Backpressure 1,0,0,1.
    run_frame(3, NF, 1, 1'b0);
    // Random latencies and random backpressure.
    for (int f = 0; f < 3; f++) run_frame($urandom_range(1, TO), NF, 2, 1'b0);
    // Zero-latency engine.
    run_frame(0, NF, 0, 1'b0);
    // Engine stall after 12 results; last one lands in DRAIN.
    run_frame(10, 12, 0, 1'b0);
    // Stall with the last result during ISSUE; error already sticky.
    run_frame(1, 12, 2, 1'b0);

    // Reset while issuing feature 7.
    eng_lat = 2;
    eng_limit = NF;
    load_inputs(1'b0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("mid_cmvn_idx", cmvn_idx, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs();
    exp_fc = 16'd0;
    exp_err = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      chk("mid_no_out", out_valid, 0);
    end
    $display("mid-frame reset at issue index 7 done");
    run_frame(4, NF, 2, 1'b0);

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    exp_fc = 16'hFFFF;
    chk("preload_frame_cnt", frame_cnt, 16'hFFFF);
    run_frame(2, NF, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
